// File: rtl/ic_global_pkg.sv
// Purpose: shared types and constants for the global-interface write drain.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state encoding, default data width, all-ones byteenable
// constant and the bytes-per-word helper.
package ic_global_pkg;

  localparam int unsigned IC_DATA_W = 32;

  // Wide enough for any practical DATA_W/8; users slice the low bits.
  localparam int unsigned IC_BE_MAX = 64;
  localparam logic [IC_BE_MAX-1:0] IC_BE_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ic_state_e;

  // WORD_BYTES = DATA_W/8: address stride of one FIFO word.
  function automatic int unsigned ic_word_bytes(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/ic_wr_hold_buf.sv
// Purpose: 2-entry holding FIFO between the scfifo read port and the Avalon write.
// Latency: a pushed word is visible on head_o the cycle after push_i.
// Backpressure: none internally; the caller keeps push within the free space
//   (a push in the same cycle as a pop is always allowed when full).
// Ports: clock/sclr; push_i + push_dat_i write the tail; pop_i drops the head;
//   count_o is occupancy 0..2; head_o is the oldest word (0 after reset).
module ic_wr_hold_buf #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         sclr,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [1:0]   count_o,
  output logic [W-1:0] head_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic [1:0]   count_d;

  // Push and pop in one cycle leave occupancy unchanged; the pointers keep order.
  always_comb begin
    count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ic_global_wr_drain.sv
// Purpose: drain cmd_len words from a non-showahead scfifo into single-beat
//   Avalon-MM writes at consecutive word addresses starting at cmd_addr.
// Latency: accept at N -> rdreq at N+1, first write at N+3, done the cycle
//   after the last accepted beat (len=0: done at N+2); one beat per cycle.
// Backpressure: avm_waitrequest holds address/data; a 2-entry hold buffer
//   throttles fifo_rdreq so no word is lost; cmd_ready is high only in IDLE.
// Ports: clock/sclr; cmd_* command handshake with busy/done status;
//   fifo_empty/fifo_rdreq/fifo_q scfifo read side; avm_* Avalon-MM write master.
module ic_global_wr_drain
  import ic_global_pkg::*;
#(
  parameter int unsigned DATA_W = IC_DATA_W,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                clock,
  input  logic                sclr,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  output logic                busy,
  output logic                done,
  input  logic                fifo_empty,
  output logic                fifo_rdreq,
  input  logic [DATA_W-1:0]   fifo_q,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest
);

  localparam int unsigned WORD_BYTES = ic_word_bytes(DATA_W);
  localparam int unsigned BE_W       = DATA_W / 8;

  ic_state_e          state_q, state_d;
  logic [ADDR_W-1:0]  addr_q,  addr_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic [LEN_W-1:0]   pops_q,  pops_d;
  logic [LEN_W-1:0]   beats_q, beats_d;
  logic               rd_inflight_q;

  logic [1:0]         buf_count;
  logic [DATA_W-1:0]  buf_head;
  logic               beat_acc;
  logic [2:0]         occ;
  logic               room;
  logic               rdreq;

  // Low address bits are discarded: commands are always word aligned.
  logic               unused_addr_lsbs;
  assign unused_addr_lsbs = ^cmd_addr[1:0];

  assign beat_acc = (buf_count != 2'd0) && !avm_waitrequest;

  // Words already committed to the buffer: stored ones plus the one whose
  // read data arrives this cycle. The beat leaving this cycle frees a slot
  // in time for a pop issued now, which is what keeps the FIFO drained at
  // one word per cycle when memory never stalls.
  assign occ   = {1'b0, buf_count} + {2'b00, rd_inflight_q};
  assign room  = (occ < 3'd2) || (beat_acc && (occ < 3'd3));
  assign rdreq = (state_q == ST_RUN) && !fifo_empty && (pops_q < len_q) && room;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    pops_d  = pops_q;
    beats_d = beats_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d  = {cmd_addr[ADDR_W-1:2], 2'b00};
          len_d   = cmd_len;
          pops_d  = '0;
          beats_d = '0;
          // len=0 also passes through RUN so done lands at N+2.
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (rdreq) begin
          pops_d = pops_q + 1'b1;
        end
        if (beat_acc) begin
          beats_d = beats_q + 1'b1;
          addr_d  = addr_q + ADDR_W'(WORD_BYTES);
        end
        // Leaving on the final acceptance puts done in the very next cycle.
        if (beats_d == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      len_q         <= '0;
      pops_q        <= '0;
      beats_q       <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      len_q         <= len_d;
      pops_q        <= pops_d;
      beats_q       <= beats_d;
      rd_inflight_q <= rdreq;
    end
  end

  // fifo_q is valid exactly one cycle after the pop; capture it then.
  ic_wr_hold_buf #(
    .W (DATA_W)
  ) u_hold_buf (
    .clock      (clock),
    .sclr       (sclr),
    .push_i     (rd_inflight_q),
    .push_dat_i (fifo_q),
    .pop_i      (beat_acc),
    .count_o    (buf_count),
    .head_o     (buf_head)
  );

  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign fifo_rdreq     = rdreq;
  assign avm_write      = (buf_count != 2'd0);
  assign avm_address    = addr_q;
  assign avm_writedata  = buf_head;
  assign avm_byteenable = avm_write ? IC_BE_ALL[BE_W-1:0] : '0;

endmodule

// File: tb/tb_ic_global_wr_drain.sv
module tb_ic_global_wr_drain;

  logic        clock = 1'b0;
  logic        sclr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic        busy;
  logic        done;
  logic        fifo_empty;
  logic        fifo_rdreq;
  logic [31:0] fifo_q;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_waitrequest;

  ic_global_wr_drain #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) dut (
    .clock           (clock),
    .sclr            (sclr),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_addr        (cmd_addr),
    .cmd_len         (cmd_len),
    .busy            (busy),
    .done            (done),
    .fifo_empty      (fifo_empty),
    .fifo_rdreq      (fifo_rdreq),
    .fifo_q          (fifo_q),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_waitrequest (avm_waitrequest)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input bit ok, input string nm, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  // ---------------- environment: scfifo model, memory slave, scoreboard ----
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } beat_t;

  logic [31:0] fifo_mem[$];   // words currently in the scfifo
  logic [31:0] src_q[$];      // words still to be trickled into the scfifo
  beat_t       exp_q[$];      // expected Avalon beats in order

  int  cyc = 0;
  int  wmode = 0;             // 0: never stall, 1: every other cycle, 2: random
  bit  pop_req = 0;
  int  first_rd, last_rd, first_wr, done_cyc, done_cnt, pops_cmd, beats_cmd;
  bit  stall_vld = 0;
  logic [31:0] stall_a, stall_d;

  always @(posedge clock) cyc++;

  // Inputs from the FIFO and slave change 2 time units after the edge.
  always @(posedge clock) begin
    #2;
    if (pop_req && fifo_mem.size() > 0) fifo_q = fifo_mem.pop_front();
    pop_req = 0;
    if (src_q.size() > 0 && (cyc % 5) == 0) fifo_mem.push_back(src_q.pop_front());
    fifo_empty = (fifo_mem.size() == 0);
    case (wmode)
      1:       avm_waitrequest = ~avm_waitrequest;
      2:       avm_waitrequest = ($urandom_range(0, 2) == 0);
      default: avm_waitrequest = 1'b0;
    endcase
  end

  // Monitor samples on the falling edge.
  always @(negedge clock) begin
    beat_t e;
    if (sclr) begin
      pop_req   = 0;
      stall_vld = 0;
    end else begin
      pop_req = fifo_rdreq;
      if (fifo_rdreq) begin
        chk(fifo_empty == 1'b0, "rdreq_while_empty", fifo_empty, 0);
        pops_cmd++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      if (avm_write) begin
        chk(avm_byteenable == 4'hF, "byteenable", avm_byteenable, 4'hF);
        if (stall_vld) begin
          chk(avm_address == stall_a, "stall_addr_stable", avm_address, stall_a);
          chk(avm_writedata == stall_d, "stall_data_stable", avm_writedata, stall_d);
        end
        if (first_wr < 0) first_wr = cyc;
        if (!avm_waitrequest) begin
          beats_cmd++;
          stall_vld = 0;
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_beat", avm_address, 0);
          end else begin
            e = exp_q.pop_front();
            chk(avm_address == e.a, "beat_addr", avm_address, e.a);
            chk(avm_writedata == e.d, "beat_data", avm_writedata, e.d);
          end
        end else begin
          stall_vld = 1;
          stall_a   = avm_address;
          stall_d   = avm_writedata;
        end
        chk(pops_cmd - beats_cmd <= 2, "outstanding_pops", pops_cmd - beats_cmd, 2);
      end else begin
        if (stall_vld) chk(1'b0, "write_dropped_while_stalled", 0, 1);
        stall_vld = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- vector table ----------------
  // Relative cycle fields: -1 = event must not occur, -2 = not checked.
  typedef struct {
    logic [31:0] addr;
    int          len;
    int          wmode;
    int          feed;        // 0: preload FIFO, 1: trickle one word per 5 cycles
    int          e_first_rd;
    int          e_last_rd;
    int          e_first_wr;
    int          e_done;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    int t;
    int rel;
    logic [31:0] w;
    @(posedge clock); #1;
    first_rd = -1; last_rd = -1; first_wr = -1; done_cyc = -1;
    done_cnt = 0; pops_cmd = 0; beats_cmd = 0;
    for (int i = 0; i < v.len; i++) begin
      w = $urandom;
      exp_q.push_back('{a: (v.addr & 32'hFFFF_FFFC) + 32'(4 * i), d: w});
      if (v.feed == 1) src_q.push_back(w);
      else             fifo_mem.push_back(w);
    end
    wmode = v.wmode;
    chk(cmd_ready == 1'b1, {nm, "_cmd_ready_idle"}, cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = v.addr;
    cmd_len   = 16'(v.len);
    n = cyc;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    chk(busy == 1'b1 && cmd_ready == 1'b0, {nm, "_busy_after_accept"}, {busy, cmd_ready}, 2'b10);
    t = 0;
    while (done_cnt == 0 && t < 500) begin
      @(posedge clock); #1;
      t++;
    end
    if (done_cnt == 0) chk(1'b0, {nm, "_done_timeout"}, t, 500);
    repeat (3) @(posedge clock);
    #1;
    wmode = 0;
    chk(done_cnt == 1, {nm, "_done_count"}, done_cnt, 1);
    chk(beats_cmd == v.len, {nm, "_beat_count"}, beats_cmd, v.len);
    chk(pops_cmd == v.len, {nm, "_pop_count"}, pops_cmd, v.len);
    chk(exp_q.size() == 0, {nm, "_beats_missing"}, exp_q.size(), 0);
    if (v.e_first_rd != -2) begin
      rel = (first_rd < 0) ? -1 : first_rd - n;
      chk(rel == v.e_first_rd, {nm, "_first_rdreq_cycle"}, rel, v.e_first_rd);
    end
    if (v.e_last_rd != -2) begin
      rel = (last_rd < 0) ? -1 : last_rd - n;
      chk(rel == v.e_last_rd, {nm, "_last_rdreq_cycle"}, rel, v.e_last_rd);
    end
    if (v.e_first_wr != -2) begin
      rel = (first_wr < 0) ? -1 : first_wr - n;
      chk(rel == v.e_first_wr, {nm, "_first_write_cycle"}, rel, v.e_first_wr);
    end
    if (v.e_done != -2) begin
      rel = (done_cyc < 0) ? -1 : done_cyc - n;
      chk(rel == v.e_done, {nm, "_done_cycle"}, rel, v.e_done);
    end
  endtask

  initial begin
    int t;
    vec_t v;
    logic [31:0] w;

    vecs[0] = '{32'h0000_1000, 4, 0, 0,  1,  4,  3,  7};   // basic
    vecs[1] = '{32'h0000_2000, 8, 1, 0,  1, -2,  3, -2};   // alternating stall
    vecs[2] = '{32'h0000_3000, 3, 0, 1, -2, -2, -2, -2};   // starved FIFO
    vecs[3] = '{32'h0000_1003, 0, 0, 0, -1, -1, -1,  2};   // len 0, misaligned
    vecs[4] = '{32'h0000_1003, 1, 0, 0,  1,  1,  3,  4};   // misaligned len 1
    vecs[5] = '{32'hFFFF_FFF8, 4, 0, 0,  1,  4,  3,  7};   // address wrap
    for (int i = 6; i < 12; i++) begin
      vecs[i] = '{$urandom, int'($urandom_range(1, 12)), 2,
                  int'($urandom_range(0, 1)), -2, -2, -2, -2};
    end

    sclr = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
    fifo_empty = 1'b1; fifo_q = '0; avm_waitrequest = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk(cmd_ready == 1'b1,     "reset_cmd_ready", cmd_ready, 1);
    chk(busy == 1'b0,          "reset_busy", busy, 0);
    chk(done == 1'b0,          "reset_done", done, 0);
    chk(fifo_rdreq == 1'b0,    "reset_rdreq", fifo_rdreq, 0);
    chk(avm_write == 1'b0,     "reset_write", avm_write, 0);
    chk(avm_address == 32'h0,  "reset_address", avm_address, 0);
    chk(avm_writedata == 32'h0, "reset_writedata", avm_writedata, 0);
    @(posedge clock); #1;
    sclr = 1'b0;

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a 6-word command, after two accepted beats.
    @(posedge clock); #1;
    first_rd = -1; last_rd = -1; first_wr = -1; done_cyc = -1;
    done_cnt = 0; pops_cmd = 0; beats_cmd = 0;
    for (int i = 0; i < 6; i++) begin
      w = $urandom;
      fifo_mem.push_back(w);
      exp_q.push_back('{a: 32'h0000_4000 + 32'(4 * i), d: w});
    end
    cmd_valid = 1'b1; cmd_addr = 32'h0000_4000; cmd_len = 16'd6;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (beats_cmd < 2 && t < 100) begin
      @(posedge clock); #1;
      t++;
    end
    chk(beats_cmd == 2, "midreset_two_beats_seen", beats_cmd, 2);
    sclr = 1'b1;
    @(posedge clock); #1;
    sclr = 1'b0;
    fifo_mem.delete(); src_q.delete(); exp_q.delete();
    @(negedge clock);
    chk(cmd_ready == 1'b1,      "midreset_cmd_ready", cmd_ready, 1);
    chk(busy == 1'b0,           "midreset_busy", busy, 0);
    chk(done == 1'b0,           "midreset_done", done, 0);
    chk(fifo_rdreq == 1'b0,     "midreset_rdreq", fifo_rdreq, 0);
    chk(avm_write == 1'b0,      "midreset_write", avm_write, 0);
    chk(avm_address == 32'h0,   "midreset_address", avm_address, 0);
    chk(avm_writedata == 32'h0, "midreset_writedata", avm_writedata, 0);
    v = '{32'h0000_5000, 2, 0, 0, 1, 2, 3, 5};
    run_vec(v, "post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
